// File: rtl/silife_spi_wb_bridge.sv
// SPI slave that decodes register-access frames and issues Wishbone master cycles.
// Frames: CMD, ADDR[23:0], then 4 write bytes (CMD 80) or dummy + 4 read bytes (CMD 00).
module silife_spi_wb_bridge #(
    parameter logic [7:0]  ADDR_HI = 8'h30,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_spi_cs,
    input  logic        i_spi_sck,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic        o_spi_miso_oe,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic        o_busy,
    output logic        o_error
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE} spi_state_t;
    typedef enum logic {WB_IDLE, WB_BUSY} wb_state_t;

    spi_state_t  spi_state;
    wb_state_t   wb_state;

    logic [2:0]  cs_s;
    logic [2:0]  sck_s;
    logic [1:0]  mosi_s;
    logic        sck_rise, sck_fall, cs_fall, cs_rise;

    logic [5:0]  bit_cnt;
    logic [31:0] shift;
    logic [31:0] next_shift;
    logic        is_write;
    logic [23:0] addr24;
    logic [31:0] miso_sr;
    logic        wr_req, rd_req;
    logic [31:0] req_data;

    logic [5:0]  tmo_cnt;
    logic [31:0] rd_data;
    logic        rd_done;
    logic        wb_timeout;

    // Two flops for metastability, the third only for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_s   <= 3'b111;
            sck_s  <= 3'b000;
            mosi_s <= 2'b00;
        end else begin
            cs_s   <= {cs_s[1:0], i_spi_cs};
            sck_s  <= {sck_s[1:0], i_spi_sck};
            mosi_s <= {mosi_s[0], i_spi_mosi};
        end
    end

    assign sck_rise   = sck_s[1] & ~sck_s[2];
    assign sck_fall   = ~sck_s[1] & sck_s[2];
    assign cs_fall    = ~cs_s[1] & cs_s[2];
    assign cs_rise    = cs_s[1] & ~cs_s[2];
    assign next_shift = {shift[30:0], mosi_s[1]};

    assign o_spi_miso_oe = ~cs_s[1];
    assign o_wb_stb      = o_wb_cyc;
    assign o_busy        = (spi_state != IDLE) || (wb_state == WB_BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            spi_state  <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            is_write   <= 1'b0;
            addr24     <= '0;
            miso_sr    <= '0;
            wr_req     <= 1'b0;
            rd_req     <= 1'b0;
            req_data   <= '0;
            o_spi_miso <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            wr_req <= 1'b0;
            rd_req <= 1'b0;
            if (wb_timeout) o_error <= 1'b1;
            if (cs_rise) begin
                spi_state  <= IDLE;
                o_spi_miso <= 1'b0;
            end else begin
                case (spi_state)
                    IDLE: if (cs_fall) begin
                        spi_state <= CMD;
                        bit_cnt   <= '0;
                        shift     <= '0;
                        o_error   <= 1'b0;
                    end
                    CMD: if (sck_rise) begin
                        shift   <= next_shift;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt <= '0;
                            if (next_shift[7:0] == 8'h80 || next_shift[7:0] == 8'h00) begin
                                is_write  <= next_shift[7];
                                spi_state <= ADDR;
                            end else begin
                                spi_state <= IGNORE;
                                o_error   <= 1'b1;
                            end
                        end
                    end
                    ADDR: if (sck_rise) begin
                        shift   <= next_shift;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd23) begin
                            bit_cnt <= '0;
                            addr24  <= next_shift[23:0];
                            if (is_write) begin
                                spi_state <= WDATA;
                            end else begin
                                spi_state <= DUMMY;
                                rd_req    <= 1'b1;
                            end
                        end
                    end
                    WDATA: if (sck_rise) begin
                        shift   <= next_shift;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd31) begin
                            bit_cnt   <= '0;
                            req_data  <= next_shift;
                            wr_req    <= 1'b1;
                            spi_state <= IGNORE;
                        end
                    end
                    DUMMY: if (sck_rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt   <= '0;
                            spi_state <= RDATA;
                            if (rd_done) begin
                                miso_sr <= rd_data;
                            end else begin
                                miso_sr <= '0;
                                o_error <= 1'b1;
                            end
                        end
                    end
                    RDATA: begin
                        // Mode 0: present on SCK fall so the host samples on the next rise.
                        if (sck_fall) begin
                            o_spi_miso <= miso_sr[31];
                            miso_sr    <= {miso_sr[30:0], 1'b0};
                        end
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd31) begin
                                spi_state  <= IGNORE;
                                o_spi_miso <= 1'b0;
                            end
                        end
                    end
                    default: o_spi_miso <= 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_state   <= WB_IDLE;
            o_wb_cyc   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= '0;
            o_wb_data  <= '0;
            tmo_cnt    <= '0;
            rd_data    <= '0;
            rd_done    <= 1'b0;
            wb_timeout <= 1'b0;
        end else begin
            wb_timeout <= 1'b0;
            case (wb_state)
                WB_IDLE: if (wr_req || rd_req) begin
                    o_wb_cyc  <= 1'b1;
                    o_wb_we   <= wr_req;
                    o_wb_addr <= {ADDR_HI, addr24};
                    o_wb_data <= wr_req ? req_data : 32'h0;
                    tmo_cnt   <= '0;
                    rd_done   <= 1'b0;
                    wb_state  <= WB_BUSY;
                end
                default: begin
                    if (i_wb_ack) begin
                        o_wb_cyc <= 1'b0;
                        if (!o_wb_we) rd_data <= i_wb_data;
                        rd_done  <= 1'b1;
                        wb_state <= WB_IDLE;
                    end else if (tmo_cnt == 6'(TIMEOUT - 1)) begin
                        o_wb_cyc   <= 1'b0;
                        wb_timeout <= 1'b1;
                        rd_data    <= '0;
                        rd_done    <= 1'b1;
                        wb_state   <= WB_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 6'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_silife_spi_wb_bridge.sv
// Randomised frame-level bench for silife_spi_wb_bridge with a Wishbone slave model
// and a frame-outcome reference model.
module tb_silife_spi_wb_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs, spi_sck, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_addr, wb_wdata;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        busy, error;

    int checks = 0;
    int errors = 0;

    silife_spi_wb_bridge dut (
        .clk           (clk),
        .reset         (reset),
        .i_spi_cs      (spi_cs),
        .i_spi_sck     (spi_sck),
        .i_spi_mosi    (spi_mosi),
        .o_spi_miso    (spi_miso),
        .o_spi_miso_oe (spi_miso_oe),
        .o_wb_cyc      (wb_cyc),
        .o_wb_stb      (wb_stb),
        .o_wb_we       (wb_we),
        .o_wb_addr     (wb_addr),
        .o_wb_data     (wb_wdata),
        .i_wb_ack      (wb_ack),
        .i_wb_data     (wb_rdata),
        .o_busy        (busy),
        .o_error       (error)
    );

    always #5 clk = ~clk;

    // Wishbone slave: acks ack_delay cycles after first seeing cyc, or never.
    bit no_ack;
    int ack_delay;
    int s_cnt;
    always @(posedge clk) begin
        if (reset || !wb_cyc) begin
            s_cnt  <= 0;
            wb_ack <= 1'b0;
        end else if (wb_ack) begin
            wb_ack <= 1'b0;
        end else if (!no_ack) begin
            if (s_cnt == ack_delay - 1) wb_ack <= 1'b1;
            s_cnt <= s_cnt + 1;
        end
    end

    // Bus monitor: one record per cyc pulse.
    logic        q_we[$];
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_len[$];
    int          cur_len = 0;
    logic        cur_we;
    logic [31:0] cur_addr, cur_data;
    always @(negedge clk) begin
        if (wb_cyc) begin
            if (cur_len == 0) begin
                cur_we   = wb_we;
                cur_addr = wb_addr;
                cur_data = wb_wdata;
            end
            cur_len++;
        end else if (cur_len != 0) begin
            q_we.push_back(cur_we);
            q_addr.push_back(cur_addr);
            q_data.push_back(cur_data);
            q_len.push_back(cur_len);
            cur_len = 0;
        end
    end

    task automatic clear_mon();
        q_we.delete();
        q_addr.delete();
        q_data.delete();
        q_len.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] tx_buf[0:8];
    logic [7:0] rx_buf[0:8];
    int         busy_fall_clks;

    // SPI mode 0 host, SCK = clk/8; MISO sampled just before each rise.
    task automatic spi_xfer(input int nbytes, input bit poll_busy);
        spi_cs = 1'b0;
        wait_clk(6);
        for (int b = 0; b < nbytes; b++) begin
            for (int i = 7; i >= 0; i--) begin
                spi_mosi = tx_buf[b][i];
                wait_clk(4);
                rx_buf[b][i] = spi_miso;
                spi_sck = 1'b1;
                wait_clk(4);
                spi_sck = 1'b0;
            end
        end
        wait_clk(6);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        busy_fall_clks = -1;
        if (poll_busy) begin
            for (int k = 1; k <= 100; k++) begin
                wait_clk(1);
                if (!busy) begin
                    busy_fall_clks = k;
                    break;
                end
            end
        end
    endtask

    // Reference model: outcome of a frame from the protocol rules alone.
    int          exp_ntxn, exp_len;
    bit          exp_we, exp_err;
    logic [31:0] exp_addr, exp_data, exp_word, rx_word;

    function automatic void model(input logic [7:0] cmd, input logic [23:0] a,
                                  input logic [31:0] d, input int nsent, input bit ack,
                                  input int dly, input logic [31:0] rdat);
        exp_ntxn = 0;
        exp_err  = 1'b0;
        exp_word = 32'h0;
        exp_we   = 1'b0;
        exp_addr = {8'h30, a};
        exp_data = d;
        exp_len  = ack ? dly + 1 : 32;
        if (cmd == 8'h80) begin
            exp_we   = 1'b1;
            exp_ntxn = (nsent >= 8) ? 1 : 0;
        end else if (cmd == 8'h00) begin
            exp_ntxn = (nsent >= 4) ? 1 : 0;
            exp_word = ack ? rdat : 32'h0;
            exp_err  = !ack;
        end else begin
            exp_err = 1'b1;
        end
    endfunction

    task automatic do_frame(input logic [7:0] cmd, input logic [23:0] a, input logic [31:0] d,
                            input int nsent, input bit ack, input int dly,
                            input logic [31:0] rdat, input bit poll);
        no_ack    = !ack;
        ack_delay = dly;
        wb_rdata  = rdat;
        tx_buf[0] = cmd;
        tx_buf[1] = a[23:16];
        tx_buf[2] = a[15:8];
        tx_buf[3] = a[7:0];
        tx_buf[4] = d[31:24];
        tx_buf[5] = d[23:16];
        tx_buf[6] = d[15:8];
        tx_buf[7] = d[7:0];
        tx_buf[8] = 8'($urandom);
        for (int i = 0; i < 9; i++) rx_buf[i] = 8'hxx;
        clear_mon();
        model(cmd, a, d, nsent, ack, dly, rdat);
        spi_xfer(nsent, poll);
        if (!poll) wait_clk(24);
        rx_word = {rx_buf[5], rx_buf[6], rx_buf[7], rx_buf[8]};
    endtask

    task automatic test_reset();
        if (wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wb_cyc); end
        if (wb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wb_stb); end
        if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wb_we); end
        if (wb_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", wb_addr); end
        if (wb_wdata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", wb_wdata); end
        if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
        if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks += 9;
    endtask

    task automatic test_write();
        for (int it = 0; it < 5; it++) begin
            logic [23:0] a;
            logic [31:0] d;
            int dly;
            a   = (it == 0) ? 24'h001000 : 24'($urandom);
            d   = (it == 0) ? 32'h000000A5 : $urandom;
            dly = (it == 0) ? 1 : int'($urandom_range(1, 10));
            do_frame(8'h80, a, d, 8, 1'b1, dly, 32'h0, 1'b0);
            checks += 6;
            if (q_len.size() !== exp_ntxn) begin
                errors++;
                $display("FAIL wr_count[%0d]: got %0d want %0d", it, q_len.size(), exp_ntxn);
            end else begin
                if (q_we[0] !== exp_we) begin errors++; $display("FAIL wr_we[%0d]: got %b want %b", it, q_we[0], exp_we); end
                if (q_addr[0] !== exp_addr) begin errors++; $display("FAIL wr_addr[%0d]: got %h want %h", it, q_addr[0], exp_addr); end
                if (q_data[0] !== exp_data) begin errors++; $display("FAIL wr_data[%0d]: got %h want %h", it, q_data[0], exp_data); end
                if (q_len[0] !== exp_len) begin errors++; $display("FAIL wr_len[%0d]: got %0d want %0d", it, q_len[0], exp_len); end
            end
            if (error !== exp_err) begin errors++; $display("FAIL wr_error[%0d]: got %b want %b", it, error, exp_err); end
        end
    endtask

    task automatic test_read();
        for (int it = 0; it < 5; it++) begin
            logic [23:0] a;
            logic [31:0] r;
            int dly;
            a   = (it == 0) ? 24'h000010 : 24'($urandom);
            r   = (it == 0) ? 32'h0000000B : $urandom;
            dly = (it == 0) ? 3 : int'($urandom_range(1, 10));
            do_frame(8'h00, a, $urandom, 9, 1'b1, dly, r, 1'b0);
            checks += 6;
            if (q_len.size() !== exp_ntxn) begin
                errors++;
                $display("FAIL rd_count[%0d]: got %0d want %0d", it, q_len.size(), exp_ntxn);
            end else begin
                if (q_we[0] !== exp_we) begin errors++; $display("FAIL rd_we[%0d]: got %b want %b", it, q_we[0], exp_we); end
                if (q_addr[0] !== exp_addr) begin errors++; $display("FAIL rd_addr[%0d]: got %h want %h", it, q_addr[0], exp_addr); end
                if (q_len[0] !== exp_len) begin errors++; $display("FAIL rd_len[%0d]: got %0d want %0d", it, q_len[0], exp_len); end
            end
            if (rx_word !== exp_word) begin errors++; $display("FAIL rd_miso[%0d]: got %h want %h", it, rx_word, exp_word); end
            if (error !== exp_err) begin errors++; $display("FAIL rd_error[%0d]: got %b want %b", it, error, exp_err); end
        end
    endtask

    task automatic test_abort();
        do_frame(8'h80, 24'($urandom), $urandom, 6, 1'b1, 1, 32'h0, 1'b1);
        wait_clk(20);
        checks += 2;
        if (q_len.size() !== exp_ntxn) begin
            errors++;
            $display("FAIL abort_count: got %0d want %0d", q_len.size(), exp_ntxn);
        end
        if (busy_fall_clks < 1 || busy_fall_clks > 4) begin
            errors++;
            $display("FAIL abort_busy_fall: got %0d clks want 1..4", busy_fall_clks);
        end
        do_frame(8'h80, 24'($urandom), $urandom, 8, 1'b1, 2, 32'h0, 1'b0);
        checks += 3;
        if (q_len.size() !== 1) begin
            errors++;
            $display("FAIL abort_next_count: got %0d want 1", q_len.size());
        end else begin
            if (q_addr[0] !== exp_addr) begin errors++; $display("FAIL abort_next_addr: got %h want %h", q_addr[0], exp_addr); end
            if (q_data[0] !== exp_data) begin errors++; $display("FAIL abort_next_data: got %h want %h", q_data[0], exp_data); end
        end
    endtask

    task automatic test_timeout();
        do_frame(8'h00, 24'($urandom), $urandom, 9, 1'b0, 1, $urandom, 1'b0);
        checks += 4;
        if (q_len.size() !== 1) begin
            errors++;
            $display("FAIL tmo_count: got %0d want 1", q_len.size());
        end else if (q_len[0] !== exp_len) begin
            errors++;
            $display("FAIL tmo_len: got %0d want %0d", q_len[0], exp_len);
        end
        if (error !== exp_err) begin errors++; $display("FAIL tmo_error: got %b want %b", error, exp_err); end
        if (rx_word !== exp_word) begin errors++; $display("FAIL tmo_miso: got %h want %h", rx_word, exp_word); end
        spi_cs = 1'b0;
        wait_clk(6);
        if (error !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", error); end
        spi_cs = 1'b1;
        wait_clk(8);
        no_ack = 1'b0;
    endtask

    task automatic test_bad_cmd();
        do_frame(8'h41, 24'($urandom), $urandom, 8, 1'b1, 1, $urandom, 1'b0);
        checks += 3;
        if (q_len.size() !== exp_ntxn) begin
            errors++;
            $display("FAIL bad_count: got %0d want %0d", q_len.size(), exp_ntxn);
        end
        if (error !== exp_err) begin errors++; $display("FAIL bad_error: got %b want %b", error, exp_err); end
        begin
            logic [7:0] acc;
            acc = 8'h00;
            for (int i = 0; i < 8; i++) acc = acc | rx_buf[i];
            if (acc !== 8'h00) begin errors++; $display("FAIL bad_miso: got %h want 00", acc); end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        do_frame(8'h80, 24'($urandom), $urandom, 8, 1'b0, 1, 32'h0, 1'b0);
        // do_frame already waited; restart with a shorter tail to catch cyc high.
        clear_mon();
        spi_xfer(8, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (wb_cyc) begin
                seen = 1'b1;
                break;
            end
            wait_clk(1);
        end
        checks += 1;
        if (!seen) begin errors++; $display("FAIL rst_mid_cyc_seen: got 0 want 1"); end
        reset = 1'b1;
        wait_clk(1);
        checks += 4;
        if (wb_cyc !== 1'b0) begin errors++; $display("FAIL rst_mid_cyc: got %b want 0", wb_cyc); end
        if (wb_stb !== 1'b0) begin errors++; $display("FAIL rst_mid_stb: got %b want 0", wb_stb); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        if (error !== 1'b0) begin errors++; $display("FAIL rst_mid_error: got %b want 0", error); end
        reset = 1'b0;
        wait_clk(4);
        do_frame(8'h80, 24'($urandom), $urandom, 8, 1'b1, 1, 32'h0, 1'b0);
        checks += 4;
        if (q_len.size() !== 1) begin
            errors++;
            $display("FAIL rst_next_count: got %0d want 1", q_len.size());
        end else begin
            if (q_we[0] !== 1'b1) begin errors++; $display("FAIL rst_next_we: got %b want 1", q_we[0]); end
            if (q_addr[0] !== exp_addr) begin errors++; $display("FAIL rst_next_addr: got %h want %h", q_addr[0], exp_addr); end
            if (q_data[0] !== exp_data) begin errors++; $display("FAIL rst_next_data: got %h want %h", q_data[0], exp_data); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        spi_cs    = 1'b1;
        spi_sck   = 1'b0;
        spi_mosi  = 1'b0;
        no_ack    = 1'b0;
        ack_delay = 1;
        wb_rdata  = 32'h0;
        wait_clk(5);
        test_reset();
        reset = 1'b0;
        wait_clk(4);
        test_write();
        test_read();
        test_abort();
        test_timeout();
        test_bad_cmd();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/silife_spi_wb_bridge.md
Name: silife_spi_wb_bridge

Overview:
- SPI slave that receives register-access frames from an external host and issues Wishbone master cycles, so the host can control the silife core (ctrl, MAX7219 config, matrix rows) without the management CPU.
- Sits in front of the silife Wishbone slave and is muxed with the CPU port at top level.
- It is the SPI receive end and Wishbone initiator, complementing the core's SPI transmit end and Wishbone responder.

Parameters:
ADDR_HI, 8'h30, upper 8 bits of every issued Wishbone address
TIMEOUT, 32, max clk cycles a Wishbone cycle waits for ack; must be ≤ 60

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
i_spi_cs  input  1  chip select, active low, asynchronous to clk
i_spi_sck  input  1  SPI clock, mode 0, asynchronous; f_sck ≤ f_clk/8
i_spi_mosi  input  1  host-to-bridge data, MSB first
o_spi_miso  output  1  bridge-to-host data
o_spi_miso_oe  output  1  MISO driver enable, high while CS is low
o_wb_cyc  output  1  Wishbone cycle
o_wb_stb  output  1  Wishbone strobe, always equal to o_wb_cyc
o_wb_we  output  1  write enable
o_wb_addr  output  32  {ADDR_HI, 24-bit frame address}
o_wb_data  output  32  write data
i_wb_ack  input  1  Wishbone acknowledge
i_wb_data  input  32  Wishbone read data
o_busy  output  1  high from CS fall until the frame and any Wishbone cycle finish
o_error  output  1  sticky timeout/protocol error; cleared on CS fall or reset

Behaviour:
- Input synchronisation: CS, SCK and MOSI each pass through 2 flops, plus a third flop for edge detection. The rise/fall of synchronised SCK defines sample and shift events.
- Reset values: all outputs 0, SPI FSM in IDLE, Wishbone FSM in WB_IDLE, shift registers 0.
- Frame format, MSB first: CMD byte, then ADDR[23:16], ADDR[15:8], ADDR[7:0].
  - CMD=8'h80 (write): followed by 4 data bytes, D[31:24] first.
  - CMD=8'h00 (read): followed by 1 dummy byte, then 4 read-data bytes driven on MISO.
- SPI FSM states: IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE.
  - IDLE→CMD on synchronised CS fall. This also clears o_error and the bit/byte counters.
  - MOSI is sampled on SCK rise; 8 rises complete a byte.
  - CMD→ADDR when CMD is 8'h80 or 8'h00. Any other CMD: →IGNORE and o_error=1.
  - ADDR→WDATA (write) or →DUMMY (read) after 3 bytes.
    - On entering DUMMY, a read request goes to the Wishbone FSM in the same cycle.
  - WDATA: after the 4th byte, a write request is issued, then →IGNORE.
  - DUMMY→RDATA after 8 SCK rises.
    - At the entry cycle, the MISO shift register loads the read data if the read completed; otherwise it loads 32'h0 and o_error=1.
    - The first falling SCK edge after entry presents bit 31 (mode 0).
  - RDATA: MISO shifts on each SCK fall. After 32 bits →IGNORE, with MISO 0.
  - IGNORE: further bytes are discarded and MISO is held 0.
  - In every state, synchronised CS rise →IDLE.
- Aborts: CS rise before the write request is issued (fewer than 32 data bits) produces no Wishbone cycle. An in-flight Wishbone cycle is never truncated by CS or by a frame abort.
- Wishbone FSM states: WB_IDLE, WB_BUSY.
  - On a request, cyc, stb, we, addr and data are registered and asserted on the next clk edge; the timeout counter is cleared.
  - In WB_BUSY, the first cycle with i_wb_ack=1 captures i_wb_data (reads), deasserts cyc/stb on the next edge and →WB_IDLE. Exactly one ack is consumed per request.
  - If TIMEOUT cycles elapse without ack: drop cyc/stb, set o_error, →WB_IDLE, read data = 32'h0.
  - A request arriving while WB_BUSY cannot occur by construction: the frame length exceeds TIMEOUT.
- o_spi_miso_oe = synchronised CS low.
- o_busy = (SPI FSM ≠ IDLE) or (Wishbone FSM = WB_BUSY).
- Reset asserted mid-frame or mid-cycle: everything returns to reset values on the next edge; cyc/stb drop immediately.
- Latency: the Wishbone write starts 2 clk after the synchronised 32nd data-bit rise. The read starts 2 clk after the 24th address-bit rise and must finish within TIMEOUT.

Test Plan:
- Write frame 80 00 10 00 00 00 00 A5, sck=clk/8, slave acks 1 cycle after stb → exactly one cycle: addr=32'h30001000, data=32'h000000A5, we=1; cyc held 2 clk; o_error=0.
- Read frame 00 00 00 10 + dummy + 4 bytes, slave returns 32'h0000000B with 3-cycle ack delay → MISO bytes 00 00 00 0B; we=0; addr=32'h30000010.
- Write frame with CS raised after 2 data bytes → no cyc pulse; o_busy falls ≤4 clk after CS rise; next full write frame succeeds normally.
- Read with slave never acking → cyc drops after exactly 32 cycles, o_error=1, MISO returns 00 00 00 00; next CS fall clears o_error.
- CMD=8'h41 followed by 7 bytes → no Wishbone cycle, o_error=1, MISO 0 throughout.
- Reset pulse while cyc=1 mid-write → cyc/stb/o_busy/o_error all 0 on the next edge; subsequent write frame is issued correctly.
